// File: rtl/bnn_cvt01_cfu.sv
// CFU-L1 binary-neural-net dot-product unit: XNOR-popcount of two operands
// behind a CFU-L1 handshake adapter with an optional one-entry response register.

module bnn_cvt01_cfu #(
    parameter int CFU_N_CFUS    = 1,
    parameter int CFU_N_STATES  = 0,
    parameter int CFU_LAT       = 0,
    parameter int CFU_RESET     = 0,
    parameter int CFU_FUNC_ID_W = 0,
    parameter int CFU_DATA_W    = 32
) (
    input  logic                                                 clk,
    input  logic                                                 rst,
    input  logic                                                 clk_en,
    input  logic                                                 req_valid,
    output logic                                                 req_ready,
    input  logic                                                 req_cfu,
    input  logic                                                 req_state,
    input  logic [((CFU_FUNC_ID_W > 0) ? CFU_FUNC_ID_W : 1)-1:0] req_func,
    input  logic [CFU_DATA_W-1:0]                                req_data0,
    input  logic [CFU_DATA_W-1:0]                                req_data1,
    output logic                                                 resp_valid,
    input  logic                                                 resp_ready,
    output logic [2:0]                                           resp_status,
    output logic [CFU_DATA_W-1:0]                                resp_data
);

    localparam int CNT_W = $clog2(CFU_DATA_W + 1);
    localparam logic [2:0] ST_OK     = 3'd0;
    localparam logic [2:0] ST_ERR_OP = 3'd2;
    localparam int unused_cfu_reset  = CFU_RESET;

    if (CFU_N_CFUS != 1) begin : g_bad_n_cfus
        $error("bnn_cvt01_cfu: CFU_N_CFUS must be 1");
    end
    if (CFU_N_STATES != 0) begin : g_bad_n_states
        $error("bnn_cvt01_cfu: CFU_N_STATES must be 0");
    end
    if (CFU_LAT != 0 && CFU_LAT != 1) begin : g_bad_lat
        $error("bnn_cvt01_cfu: CFU_LAT must be 0 or 1");
    end
    if (CFU_DATA_W != 32 && CFU_DATA_W != 64) begin : g_bad_data_w
        $error("bnn_cvt01_cfu: CFU_DATA_W must be 32 or 64");
    end

    // CFU ID and state ID are decoded away; only one unit and no state contexts exist.
    logic unused_req_fields;
    assign unused_req_fields = ^{req_cfu, req_state, req_func};

    // L0 core: agreement bits between the two +/-1 vectors, then count them.
    logic [CFU_DATA_W-1:0] match_bits;
    logic [CNT_W-1:0]      pop_cnt;
    logic                  func_ok;
    logic [CFU_DATA_W-1:0] core_data;
    logic [2:0]            core_status;

    assign match_bits = ~(req_data0 ^ req_data1);

    always_comb begin
        pop_cnt = '0;
        for (int i = 0; i < CFU_DATA_W; i++) begin
            pop_cnt = pop_cnt + CNT_W'(match_bits[i]);
        end
    end

    if (CFU_FUNC_ID_W > 0) begin : g_func_decode
        assign func_ok = (req_func == '0);
    end else begin : g_single_func
        assign func_ok = 1'b1;
    end

    assign core_data   = func_ok ? {{(CFU_DATA_W - CNT_W){1'b0}}, pop_cnt} : '0;
    assign core_status = func_ok ? ST_OK : ST_ERR_OP;

    // L1 adapter
    if (CFU_LAT == 0) begin : g_lat0
        logic unused_seq;
        assign unused_seq  = ^{clk, rst, clk_en};

        assign req_ready   = resp_ready;
        assign resp_valid  = req_valid;
        assign resp_data   = core_data;
        assign resp_status = core_status;
    end else begin : g_lat1
        logic                  out_valid;
        logic [CFU_DATA_W-1:0] out_data;
        logic [2:0]            out_status;
        logic                  req_accept;
        logic                  resp_take;

        assign req_ready  = !out_valid || resp_ready;
        assign req_accept = req_valid && req_ready;
        assign resp_take  = out_valid && resp_ready;

        // A same-cycle consume and accept reloads the register and keeps it valid.
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                out_valid  <= 1'b0;
                out_data   <= '0;
                out_status <= ST_OK;
            end else if (clk_en) begin
                if (req_accept) begin
                    out_valid  <= 1'b1;
                    out_data   <= core_data;
                    out_status <= core_status;
                end else if (resp_take) begin
                    out_valid  <= 1'b0;
                end
            end
        end

        assign resp_valid  = out_valid;
        assign resp_data   = out_data;
        assign resp_status = out_status;
    end

endmodule

// File: tb/tb_bnn_cvt01_cfu.sv
// Bench for bnn_cvt01_cfu: three instances (32b/LAT0, 64b/LAT1, 32b/LAT1 with
// function IDs), a queue-based response model and hand-computed literal checks.

module tb_bnn_cvt01_cfu;

    typedef struct {
        logic [63:0] data;
        logic [2:0]  status;
    } resp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int tests    = 0;
    int failures = 0;

    // dut0: DATA_W 32, LAT 0
    logic        v0 = 0, rdy0 = 1, rr0, rv0;
    logic [31:0] a0 = 0, b0 = 0, rd0;
    logic [2:0]  rs0;
    logic [0:0]  f0 = 0;

    // dut1: DATA_W 64, LAT 1
    logic        v1 = 0, rdy1 = 1, en1 = 1, rr1, rv1;
    logic [63:0] a1 = 0, b1 = 0, rd1;
    logic [2:0]  rs1;
    logic [0:0]  f1 = 0;

    // dut2: DATA_W 32, LAT 1, FUNC_ID_W 2
    logic        v2 = 0, rdy2 = 1, rr2, rv2;
    logic [31:0] a2 = 0, b2 = 0, rd2;
    logic [2:0]  rs2;
    logic [1:0]  f2 = 0;

    bnn_cvt01_cfu #(.CFU_LAT(0), .CFU_DATA_W(32), .CFU_FUNC_ID_W(0)) dut0 (
        .clk(clk), .rst(rst), .clk_en(1'b1),
        .req_valid(v0), .req_ready(rr0), .req_cfu(1'b0), .req_state(1'b0),
        .req_func(f0), .req_data0(a0), .req_data1(b0),
        .resp_valid(rv0), .resp_ready(rdy0), .resp_status(rs0), .resp_data(rd0)
    );

    bnn_cvt01_cfu #(.CFU_LAT(1), .CFU_DATA_W(64), .CFU_FUNC_ID_W(0)) dut1 (
        .clk(clk), .rst(rst), .clk_en(en1),
        .req_valid(v1), .req_ready(rr1), .req_cfu(1'b0), .req_state(1'b0),
        .req_func(f1), .req_data0(a1), .req_data1(b1),
        .resp_valid(rv1), .resp_ready(rdy1), .resp_status(rs1), .resp_data(rd1)
    );

    bnn_cvt01_cfu #(.CFU_LAT(1), .CFU_DATA_W(32), .CFU_FUNC_ID_W(2)) dut2 (
        .clk(clk), .rst(rst), .clk_en(1'b1),
        .req_valid(v2), .req_ready(rr2), .req_cfu(1'b0), .req_state(1'b0),
        .req_func(f2), .req_data0(a2), .req_data1(b2),
        .resp_valid(rv2), .resp_ready(rdy2), .resp_status(rs2), .resp_data(rd2)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Dot product of two +/-1 vectors as count of agreeing bits; nonzero function is an error.
    function automatic resp_t model_resp(input logic [63:0] a, input logic [63:0] b,
                                         input int w, input int func);
        resp_t r;
        logic [63:0] mask;
        mask = (w == 64) ? {64{1'b1}} : ((64'd1 << w) - 64'd1);
        if (func != 0) begin
            r.data   = 64'd0;
            r.status = 3'd2;
        end else begin
            r.data   = 64'($countones(~(a ^ b) & mask));
            r.status = 3'd0;
        end
        return r;
    endfunction

    resp_t q1[$];
    resp_t q2[$];

    // Every-cycle comparison against the model, sampled away from the rising edge.
    always @(negedge clk) begin
        resp_t e;
        if (rst) begin
            q1.delete();
            q2.delete();
        end else begin
            check("l0_valid", 64'(rv0), 64'(v0));
            check("l0_ready", 64'(rr0), 64'(rdy0));
            if (v0) begin
                e = model_resp(64'(a0), 64'(b0), 32, 0);
                check("l0_data", 64'(rd0), e.data);
                check("l0_status", 64'(rs0), 64'(e.status));
            end

            check("l1_valid", 64'(rv1), 64'(q1.size() != 0));
            check("l1_ready", 64'(rr1), 64'((q1.size() == 0) || rdy1));
            if (rv1 && q1.size() != 0) begin
                check("l1_data", rd1, q1[0].data);
                check("l1_status", 64'(rs1), 64'(q1[0].status));
                if (rdy1 && en1) void'(q1.pop_front());
            end
            if (v1 && rr1 && en1) q1.push_back(model_resp(a1, b1, 64, 0));

            check("l2_valid", 64'(rv2), 64'(q2.size() != 0));
            check("l2_ready", 64'(rr2), 64'((q2.size() == 0) || rdy2));
            if (rv2 && q2.size() != 0) begin
                check("l2_data", 64'(rd2), q2[0].data);
                check("l2_status", 64'(rs2), 64'(q2[0].status));
                if (rdy2) void'(q2.pop_front());
            end
            if (v2 && rr2) q2.push_back(model_resp(64'(a2), 64'(b2), 32, int'(f2)));
        end
    end

    initial begin
        // Reset state
        #3;
        check("rst_l1_valid", 64'(rv1), 64'd0);
        check("rst_l1_data", rd1, 64'd0);
        check("rst_l1_status", 64'(rs1), 64'd0);
        check("rst_l1_ready", 64'(rr1), 64'd1);
        check("rst_l2_valid", 64'(rv2), 64'd0);
        check("rst_l2_ready", 64'(rr2), 64'd1);
        @(posedge clk);
        @(posedge clk); #1;
        rst = 1'b0;

        // LAT 0, 32-bit
        @(posedge clk); #1;
        v0 = 1; a0 = 32'h0; b0 = 32'h0; #1;
        check("l0_zero_eq", 64'(rd0), 64'd32);
        check("l0_zero_eq_st", 64'(rs0), 64'd0);
        check("l0_zero_eq_v", 64'(rv0), 64'd1);
        @(posedge clk); #1;
        a0 = 32'hFFFF_FFFF; b0 = 32'h0; #1;
        check("l0_complement", 64'(rd0), 64'd0);
        @(posedge clk); #1;
        a0 = 32'h0F0F_0F0F; b0 = 32'h00FF_00FF; #1;
        check("l0_mixed", 64'(rd0), 64'd16);
        for (int i = 0; i < 20; i++) begin
            @(posedge clk); #1;
            v0   = 1'($urandom_range(0, 1));
            rdy0 = 1'($urandom_range(0, 1));
            a0   = $urandom;
            b0   = $urandom;
        end
        @(posedge clk); #1;
        v0 = 0; rdy0 = 1;

        // LAT 1, 64-bit, back-to-back then backpressure
        @(posedge clk); #1;
        v1 = 1; rdy1 = 1; a1 = 64'h1234_5678_9ABC_DEF0; b1 = 64'h1234_5678_9ABC_DEF0;
        #1 check("l1_pre_valid", 64'(rv1), 64'd0);
        @(posedge clk); #1;
        check("l1_eq_valid", 64'(rv1), 64'd1);
        check("l1_eq_data", rd1, 64'd64);
        a1 = 64'hAAAA_AAAA_AAAA_AAAA; b1 = 64'h5555_5555_5555_5555;
        @(posedge clk); #1;
        check("l1_alt_data", rd1, 64'd0);
        a1 = 64'hFFFF_0000_FFFF_0000; b1 = 64'h0;
        @(posedge clk); #1;
        check("l1_half_data", rd1, 64'd32);
        rdy1 = 0; a1 = 64'h0000_0000_0000_00FF; b1 = 64'h0; #1;
        check("bp_ready_low", 64'(rr1), 64'd0);
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            check("bp_hold_ready", 64'(rr1), 64'd0);
            check("bp_hold_valid", 64'(rv1), 64'd1);
            check("bp_hold_data", rd1, 64'd32);
        end
        rdy1 = 1;
        @(posedge clk); #1;
        check("bp_resume_data", rd1, 64'd56);
        for (int i = 0; i < 8; i++) begin
            a1 = {$urandom, $urandom};
            b1 = {$urandom, $urandom};
            @(posedge clk); #1;
            check("burst_valid", 64'(rv1), 64'd1);
        end
        v1 = 0;
        @(posedge clk); #1;
        check("burst_drained", 64'(rv1), 64'd0);

        // Clock enable low: register holds, no transfer
        en1 = 0; v1 = 1; a1 = 64'h0; b1 = 64'h0;
        repeat (2) @(posedge clk);
        #1 check("en_hold_valid", 64'(rv1), 64'd0);
        en1 = 1;
        @(posedge clk); #1;
        check("en_resume_valid", 64'(rv1), 64'd1);
        check("en_resume_data", rd1, 64'd64);
        v1 = 0;
        @(posedge clk); #1;

        // Function decode, FUNC_ID_W 2
        v2 = 1; rdy2 = 1; f2 = 2'd1; a2 = 32'h1234_5678; b2 = 32'h1234_5678;
        @(posedge clk); #1;
        check("func1_status", 64'(rs2), 64'd2);
        check("func1_data", 64'(rd2), 64'd0);
        f2 = 2'd0; a2 = 32'h0F0F_0F0F; b2 = 32'h00FF_00FF;
        @(posedge clk); #1;
        check("func0_status", 64'(rs2), 64'd0);
        check("func0_data", 64'(rd2), 64'd16);
        f2 = 2'd3; a2 = 32'h0; b2 = 32'h0;
        @(posedge clk); #1;
        check("func3_status", 64'(rs2), 64'd2);
        check("func3_data", 64'(rd2), 64'd0);
        f2 = 2'd0;
        @(posedge clk); #1;
        check("func0b_data", 64'(rd2), 64'd32);
        v2 = 0;
        @(posedge clk); #1;

        // Reset with a response in flight
        v1 = 1; rdy1 = 0; a1 = 64'h1; b1 = 64'h1;
        @(posedge clk); #1;
        v1 = 0;
        check("pre_rst_valid", 64'(rv1), 64'd1);
        check("pre_rst_data", rd1, 64'd64);
        #2 rst = 1;
        #1;
        check("async_rst_valid", 64'(rv1), 64'd0);
        check("async_rst_data", rd1, 64'd0);
        check("async_rst_status", 64'(rs1), 64'd0);
        @(posedge clk); #1;
        rst = 0;
        check("post_rst_ready", 64'(rr1), 64'd1);
        rdy1 = 1; v1 = 1; a1 = 64'hF; b1 = 64'h0;
        @(posedge clk); #1;
        check("post_rst_valid", 64'(rv1), 64'd1);
        check("post_rst_data", rd1, 64'd60);
        v1 = 0;
        repeat (3) @(posedge clk);
        #1;

        $display("[TB] %0d tests run, %0d failed", tests, failures);
        $finish;
    end

endmodule

// File: doc/bnn_cvt01_cfu.md
# bnn_cvt01_cfu

Pipelined CFU-L1 binary-neural-net dot-product unit. It computes the XNOR-popcount of two DATA_W-bit operands (32 or 64 bits of ±1 weights/activations encoded as bits). Internally a CFU-L1 to CFU-L0 adapter (handshake, optional response register) feeds a combinational CFU-L0 XNOR-popcount core. It sits on the processor's custom-function-unit port; one request yields exactly one response, in order.

## Interface

Parameters:
- CFU_N_CFUS, 1, number of CFU IDs decoded; only 1 supported.
- CFU_N_STATES, 0, state contexts; must be 0 (elaboration error otherwise).
- CFU_LAT, 0, response latency in cycles; 0 or 1 only.
- CFU_RESET, 0, reserved; no effect.
- CFU_FUNC_ID_W, 0, function ID width; 0 means a single function.
- CFU_DATA_W, 32, operand/result width; 32 or 64 only.

Ports (zero-width fields are carried as 1 bit and ignored):
- clk, input, 1, rising-edge clock.
- rst, input, 1, asynchronous active-high reset.
- clk_en, input, 1, clock enable; registers hold when low.
- req_valid, input, 1, request valid.
- req_ready, output, 1, request accepted when high with req_valid.
- req_cfu, input, 1, CFU ID; ignored.
- req_state, input, 1, state ID; ignored.
- req_func, input, max(1,CFU_FUNC_ID_W), function ID.
- req_data0, input, CFU_DATA_W, operand A.
- req_data1, input, CFU_DATA_W, operand B.
- resp_valid, output, 1, response valid.
- resp_ready, input, 1, consumer ready.
- resp_status, output, 3, 0 = OK, 2 = ERROR_OP.
- resp_data, output, CFU_DATA_W, result.

## Operation

- Core result: popcount(~(req_data0 ^ req_data1)), zero-extended to CFU_DATA_W. Range 0..CFU_DATA_W. Equal operands give CFU_DATA_W; complementary operands give 0.
- When CFU_FUNC_ID_W = 0, every request is function 0.
- When CFU_FUNC_ID_W > 0, req_func == 0 gives the result with status 0. Any other value gives resp_data = 0 and status 2 (ERROR_OP).
- Transfer rules: a request transfers on req_valid && req_ready. A response transfers on resp_valid && resp_ready.
- No reordering and no dropping. Exactly one response per accepted request.
- CFU_LAT = 0 (pure adapter, no state):
  - resp_valid = req_valid; req_ready = resp_ready.
  - resp_data and resp_status are combinational from the request.
  - clk, rst and clk_en are unused.
- CFU_LAT = 1 (one-entry output register: out_valid, out_data, out_status):
  - req_ready = !out_valid || resp_ready.
  - On a clk edge with clk_en high:
    - request accepted: load the result and status, set out_valid = 1.
    - else if the response is consumed: clear out_valid.
  - Outputs: resp_valid = out_valid, resp_data = out_data, resp_status = out_status.
- Reset (CFU_LAT = 1): out_valid = 0, out_data = 0, out_status = 0, so resp_valid = 0, resp_data = 0, resp_status = 0.
  - Reset mid-operation discards the in-flight response.
  - req_ready is 1 after reset.

## Timing

- LAT 0: zero-cycle combinational path from request to response. Throughput 1/cycle while resp_ready is high.
- LAT 1: response valid the cycle after acceptance. Sustains 1/cycle when resp_ready is held high.
- Simultaneous response consume and new accept in one cycle: the register reloads and out_valid stays 1.
- Backpressure: if resp_ready is low with out_valid = 1, req_ready = 0 and resp_data/resp_status are held stable.
- clk_en low: the register holds. Handshake signals are still computed combinationally from the held state, so the consumer may sample but state does not advance. Integrators must gate req_valid/resp_ready accordingly.
- rst asserts asynchronously (outputs clear immediately) and is released synchronously to clk by the integrator.

## Test plan

- Basic, DATA_W 32, LAT 0:
  - data0 = 0, data1 = 0 -> resp_data 32, status 0, same cycle.
  - data0 = 0xFFFFFFFF, data1 = 0 -> 0.
- Mixed, DATA_W 32: data0 = 0x0F0F0F0F, data1 = 0x00FF00FF -> resp_data 16.
  - Random operands are checked against a software popcount model.
- DATA_W 64, LAT 1:
  - data0 = data1 = 0x123456789ABCDEF0 -> 64 the cycle after acceptance.
  - data0 = 0xAAAAAAAAAAAAAAAA, data1 = 0x5555555555555555 -> 0.
- Backpressure, LAT 1:
  - Hold resp_ready low for 3 cycles after the first response -> req_ready 0, resp_data stable, no request lost.
  - Then drive back-to-back requests with resp_ready high -> one response per cycle, in order.
- Function error, CFU_FUNC_ID_W = 2: req_func = 1 -> status 2, data 0; req_func = 0 -> normal result.
- Reset, LAT 1:
  - Assert rst while resp_valid = 1 -> resp_valid, resp_data and resp_status go to 0 immediately.
  - After release, req_ready = 1 and the next request completes normally.
